// File: rtl/mat_result_checker.sv
// Streams DEPTH result words and golden words through a shared read port and
// compares them. Reports the mismatch count, the first failing address and an overall pass flag.
module mat_result_checker #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12,
    parameter int DW    = 22
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] dut_data,
    input  logic [DW-1:0] gold_data,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW:0]   err_cnt,
    output logic [AW-1:0] first_err_addr,
    output logic          first_err_vld
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] cnt;
    logic          cmp_vld;
    logic [AW-1:0] cmp_addr;
    logic          last_addr;
    logic          accept;
    logic          mism;

    assign last_addr = (cnt == AW'(DEPTH - 1));
    assign accept    = (state == IDLE) && start;
    assign mism      = cmp_vld && (dut_data != gold_data);

    // Read port decodes straight from state and counter so the memories see
    // the address in the same cycle the FSM enters READ.
    assign rd_en   = (state == READ);
    assign rd_addr = (state == READ) ? cnt : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    if (last_addr) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            cmp_vld        <= 1'b0;
            cmp_addr       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            first_err_vld  <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt == READ) || (state_nxt == DRAIN);
            done     <= (state_nxt == DONE);
            cmp_vld  <= rd_en;
            cmp_addr <= cnt;
            if (accept) begin
                cnt            <= '0;
                err_cnt        <= '0;
                pass           <= 1'b0;
                first_err_addr <= '0;
                first_err_vld  <= 1'b0;
            end else begin
                if ((state == READ) && !last_addr)
                    cnt <= cnt + AW'(1);
                if (mism) begin
                    err_cnt <= err_cnt + (AW+1)'(1);
                    if (!first_err_vld) begin
                        first_err_addr <= cmp_addr;
                        first_err_vld  <= 1'b1;
                    end
                end
                // The last compare lands in DRAIN, so fold it into pass here.
                if (state == DRAIN)
                    pass <= (err_cnt == '0) && !mism;
            end
        end
    end

endmodule
